// File: rtl/life_pkg.sv
// Shared state type and cell indexing helper for the Game of Life engine.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_next.sv
// Combinational next-generation calculator: applies Conway B3/S23 to every cell.
module life_next
  import life_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int WRAP = 0
) (
  input  logic [ROWS*COLS-1:0] grid,
  output logic [ROWS*COLS-1:0] nxt
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [8:0] nb;
      logic [3:0] cnt;

      // 3x3 window around the cell; position 4 is the cell itself and never counts.
      for (genvar d = 0; d < 9; d++) begin : g_nb
        localparam int RR = r + d / 3 - 1;
        localparam int CC = c + d % 3 - 1;
        localparam int RW = (RR + ROWS) % ROWS;
        localparam int CW = (CC + COLS) % COLS;
        if (d == 4) begin : g_self
          assign nb[d] = 1'b0;
        end else if (WRAP != 0) begin : g_wrap
          assign nb[d] = grid[idx(RW, CW, COLS)];
        end else if (RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS) begin : g_in
          assign nb[d] = grid[idx(RR, CC, COLS)];
        end else begin : g_out
          assign nb[d] = 1'b0;
        end
      end

      always_comb begin
        cnt = '0;
        for (int i = 0; i < 9; i++) begin
          cnt = cnt + {3'b000, nb[i]};
        end
      end

      assign nxt[idx(r, c, COLS)] = (cnt == 4'd3) ||
                                    (grid[idx(r, c, COLS)] && (cnt == 4'd2));
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: grid register, run/step FSM, generation counter and
// extinction/stability flags around the combinational life_next calculator.
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 load,
  input  logic                 run,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 extinct,
  output logic                 stable,
  output logic                 running
);

  localparam logic [GEN_W-1:0] GEN_MAX = '1;

  state_t                 state, state_next;
  logic [ROWS*COLS-1:0]   nxt;
  logic                   evolve;
  logic                   changed;
  logic [GEN_W-1:0]       gen_after;

  life_next #(
    .ROWS(ROWS),
    .COLS(COLS),
    .WRAP(WRAP)
  ) u_next (
    .grid(grid),
    .nxt (nxt)
  );

  // Count value after an evolve attempt; a no-change attempt leaves it alone.
  assign changed   = (nxt != grid);
  assign gen_after = !changed                ? gen_count :
                     (gen_count == GEN_MAX)  ? gen_count :
                                               gen_count + GEN_W'(1);

  always_comb begin
    state_next = state;
    evolve     = 1'b0;
    if (load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run) state_next = RUN;
          else if (step) evolve = 1'b1;
        end
        RUN: begin
          if (!run) begin
            state_next = IDLE;
          end else begin
            evolve = 1'b1;
            if (!changed || (nxt == '0) || (gen_after == GEN_MAX)) state_next = HALT;
          end
        end
        HALT: begin
          if (!run) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grid      <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        grid      <= seed;
        gen_count <= '0;
        stable    <= 1'b0;
      end else if (evolve) begin
        if (changed) begin
          grid      <= nxt;
          gen_count <= gen_after;
          stable    <= 1'b0;
        end else begin
          stable <= 1'b1;
        end
      end
    end
  end

  assign extinct = (grid == '0);
  assign running = (state == RUN);

endmodule
